// File: rtl/sprite_renderer.sv
// Sprite overlay: draws one SPRITE_SIZE^2 texture over the video stream at (sx,sy).
// Latency: 2 pix_ce strobes from coordinates/timing to colour and timing outputs.
// Backpressure: pos_ready drops while a position is pending and returns at the next frame boundary.
//
// Optional feature macro: SPRITE_SCALE2X_EN (each texel drawn as a 2x2 pixel block).
// Ports:
//   clk, pixel_reset_n             - clock, async active-low reset
//   pix_ce                         - pixel strobe; all video-path state advances only on it
//   horiz_pos, vert_pos            - current pixel coordinates
//   data_enable, horiz_sync, vert_sync - incoming timing (syncs active-low)
//   pos_valid/pos_ready, pos_x/pos_y   - position update handshake (one-entry buffer)
//   rom_addr / rom_data            - texel fetch ({row,col}); data valid one strobe later
//   vga_r/g/b, hsync_o, vsync_o, de_o  - aligned video outputs
module sprite_renderer #(
    parameter int          COORDINATE_WIDTH = 10,
    parameter int          H_RESOLUTION     = 640,
    parameter int          V_RESOLUTION     = 480,
    parameter int          SPRITE_SIZE      = 16,
    parameter int          INIT_X           = 312,
    parameter int          INIT_Y           = 232,
    parameter logic [11:0] KEY_COLOR        = 12'hF0F,
    parameter logic [11:0] BG_COLOR         = 12'h000
) (
    input  logic                                 clk,
    input  logic                                 pixel_reset_n,
    input  logic                                 pix_ce,
    input  logic [COORDINATE_WIDTH-1:0]          horiz_pos,
    input  logic [COORDINATE_WIDTH-1:0]          vert_pos,
    input  logic                                 data_enable,
    input  logic                                 horiz_sync,
    input  logic                                 vert_sync,
    input  logic                                 pos_valid,
    input  logic [COORDINATE_WIDTH-1:0]          pos_x,
    input  logic [COORDINATE_WIDTH-1:0]          pos_y,
    output logic                                 pos_ready,
    output logic [2*$clog2(SPRITE_SIZE)-1:0]     rom_addr,
    input  logic [11:0]                          rom_data,
    output logic [3:0]                           vga_r,
    output logic [3:0]                           vga_g,
    output logic [3:0]                           vga_b,
    output logic                                 hsync_o,
    output logic                                 vsync_o,
    output logic                                 de_o
);
    localparam int CW = COORDINATE_WIDTH;
    localparam int AW = $clog2(SPRITE_SIZE);
`ifdef SPRITE_SCALE2X_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    localparam int FOOT = SPRITE_SIZE << SH;

    // Elaboration-time sanity checks on the configuration.
    if ((SPRITE_SIZE & (SPRITE_SIZE - 1)) != 0) begin : g_size_chk
        $error("SPRITE_SIZE must be a power of two");
    end
    if (INIT_X >= H_RESOLUTION || INIT_Y >= V_RESOLUTION) begin : g_init_chk
        $error("initial sprite position lies outside the active area");
    end

    // Position state
    logic [CW-1:0] sx_q, sy_q, buf_x_q, buf_y_q;
    logic          pending_q;
    logic          frame_bound;
    logic          accept;

    // Stage 1
    logic          hit_q, hit_d;
    logic [2*AW-1:0] rom_addr_q, rom_addr_d;
    logic          de1_q, hs1_q, vs1_q;

    // Stage 2
    logic [11:0]   colour_q, colour_d;
    logic          de2_q, hs2_q, vs2_q;

    // Extended-width compare: a sprite near the right/bottom edge clips instead of wrapping.
    logic [CW:0]   x_end, y_end;
    logic [CW-1:0] dx, dy;

    assign frame_bound = pix_ce && (horiz_pos == '0) && (vert_pos == CW'(V_RESOLUTION));
    assign accept      = pos_valid && !pending_q;
    assign pos_ready   = !pending_q;

    assign x_end = {1'b0, sx_q} + (CW+1)'(FOOT);
    assign y_end = {1'b0, sy_q} + (CW+1)'(FOOT);
    assign dx    = horiz_pos - sx_q;
    assign dy    = vert_pos  - sy_q;

    always_comb begin
        hit_d      = (horiz_pos >= sx_q) && ({1'b0, horiz_pos} < x_end) &&
                     (vert_pos  >= sy_q) && ({1'b0, vert_pos}  < y_end);
        rom_addr_d = {dy[SH +: AW], dx[SH +: AW]};
    end

    always_comb begin
        colour_d = BG_COLOR;
        if (!de1_q) begin
            colour_d = 12'h000;
        end else if (hit_q && (rom_data != KEY_COLOR)) begin
            colour_d = rom_data;
        end
    end

    // Position buffer: accepts on any clk edge, applies only at a frame boundary.
    // A request accepted on the boundary itself lands in the buffer and waits a frame.
    always_ff @(posedge clk or negedge pixel_reset_n) begin
        if (!pixel_reset_n) begin
            sx_q      <= CW'(INIT_X);
            sy_q      <= CW'(INIT_Y);
            buf_x_q   <= '0;
            buf_y_q   <= '0;
            pending_q <= 1'b0;
        end else if (frame_bound && pending_q) begin
            sx_q      <= buf_x_q;
            sy_q      <= buf_y_q;
            pending_q <= 1'b0;
        end else if (accept) begin
            buf_x_q   <= pos_x;
            buf_y_q   <= pos_y;
            pending_q <= 1'b1;
        end
    end

    // Two-stage video pipeline; everything holds while pix_ce is low.
    always_ff @(posedge clk or negedge pixel_reset_n) begin
        if (!pixel_reset_n) begin
            hit_q      <= 1'b0;
            rom_addr_q <= '0;
            de1_q      <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            colour_q   <= 12'h000;
            de2_q      <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
        end else if (pix_ce) begin
            hit_q      <= hit_d;
            rom_addr_q <= rom_addr_d;
            de1_q      <= data_enable;
            hs1_q      <= horiz_sync;
            vs1_q      <= vert_sync;
            colour_q   <= colour_d;
            de2_q      <= de1_q;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
        end
    end

    assign rom_addr = rom_addr_q;
    assign vga_r    = colour_q[11:8];
    assign vga_g    = colour_q[7:4];
    assign vga_b    = colour_q[3:0];
    assign hsync_o  = hs2_q;
    assign vsync_o  = vs2_q;
    assign de_o     = de2_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomized bench for sprite_renderer against a queue-based reference model.
module tb_sprite_renderer;
    localparam int          CW   = 10;
    localparam int          S    = 16;
    localparam int          AW   = 4;
    localparam int          VRES = 480;
    localparam int          IX   = 312;
    localparam int          IY   = 232;
    localparam logic [11:0] KEY  = 12'hF0F;
    localparam logic [11:0] BG   = 12'h248;
`ifdef SPRITE_SCALE2X_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    localparam int FOOT = S << SH;

    typedef struct packed {
        logic [11:0] col;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;

    localparam exp_t IDLE = '{col: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0};

    logic clk = 1'b0;
    logic pixel_reset_n, pix_ce;
    logic [CW-1:0] horiz_pos, vert_pos, pos_x, pos_y;
    logic data_enable, horiz_sync, vert_sync, pos_valid, pos_ready;
    logic [2*AW-1:0] rom_addr;
    logic [11:0] rom_data;
    logic [3:0] vga_r, vga_g, vga_b;
    logic hsync_o, vsync_o, de_o;

    always #5 clk = ~clk;

    sprite_renderer #(
        .COORDINATE_WIDTH(CW), .H_RESOLUTION(640), .V_RESOLUTION(VRES),
        .SPRITE_SIZE(S), .INIT_X(IX), .INIT_Y(IY),
        .KEY_COLOR(KEY), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .pixel_reset_n(pixel_reset_n), .pix_ce(pix_ce),
        .horiz_pos(horiz_pos), .vert_pos(vert_pos),
        .data_enable(data_enable), .horiz_sync(horiz_sync), .vert_sync(vert_sync),
        .pos_valid(pos_valid), .pos_x(pos_x), .pos_y(pos_y), .pos_ready(pos_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
    );

    // Texture: transparent at texel 0 and every texel whose low bits are 5.
    function automatic logic [11:0] rom_fn(input logic [7:0] a);
        if (a == 8'd0 || a[2:0] == 3'd5) return KEY;
        return {a[3:0], ~a[7:4], a[7:4] ^ a[3:0]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    // Reference model state
    int        m_sx, m_sy, m_bx, m_by;
    bit        m_pend;
    exp_t      q[$];
    exp_t      m_out;
    logic [7:0] m_addr;

    int n_pass = 0;
    int n_total = 0;
    bit req_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_sx = IX; m_sy = IY; m_pend = 1'b0;
        q = {};
        q.push_back(IDLE);
        m_out = IDLE;
        m_addr = 8'd0;
    endtask

    // One clk edge of the model; returns whether the position request was taken.
    task automatic model_edge(output bit acc);
        acc = 1'b0;
        if (pix_ce) begin
            int dx, dy, row, col;
            bit hit;
            logic [7:0] ta;
            logic [11:0] tex;
            exp_t e;
            dx  = int'(horiz_pos) - m_sx;
            dy  = int'(vert_pos) - m_sy;
            hit = (dx >= 0) && (dx < FOOT) && (dy >= 0) && (dy < FOOT);
            row = ((dy & ((1 << CW) - 1)) >> SH) % S;
            col = ((dx & ((1 << CW) - 1)) >> SH) % S;
            ta  = 8'(row * S + col);
            tex = rom_fn(ta);
            e.de = data_enable;
            e.hs = horiz_sync;
            e.vs = vert_sync;
            if (!data_enable)               e.col = 12'h000;
            else if (hit && tex != KEY)     e.col = tex;
            else                            e.col = BG;
            q.push_back(e);
            m_out  = q.pop_front();
            m_addr = ta;
        end
        if (pix_ce && horiz_pos == 0 && vert_pos == VRES && m_pend) begin
            m_sx = m_bx; m_sy = m_by; m_pend = 1'b0;
        end else if (pos_valid && !m_pend) begin
            m_bx = pos_x; m_by = pos_y; m_pend = 1'b1; acc = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("colour",    32'({vga_r, vga_g, vga_b}), 32'(m_out.col));
        check("hsync_o",   32'(hsync_o),   32'(m_out.hs));
        check("vsync_o",   32'(vsync_o),   32'(m_out.vs));
        check("de_o",      32'(de_o),      32'(m_out.de));
        check("pos_ready", 32'(pos_ready), 32'(!m_pend));
        check("rom_addr",  32'(rom_addr),  32'(m_addr));
    endtask

    function automatic int pick_x();
        case ($urandom % 4)
            0:       return 635;
            1:       return 600 + int'($urandom % 40);
            2:       return int'($urandom % 1024);
            default: return 300 + int'($urandom % 40);
        endcase
    endfunction

    function automatic int pick_y();
        case ($urandom % 4)
            0:       return 100;
            1:       return 460 + int'($urandom % 30);
            2:       return int'($urandom % 1024);
            default: return 220 + int'($urandom % 30);
        endcase
    endfunction

    task automatic drive_inputs();
        int r;
        pix_ce = ($urandom % 4) != 0;
        r = int'($urandom % 10);
        if (r < 5) begin
            horiz_pos = CW'(m_sx - 3 + int'($urandom % (FOOT + 6)));
            vert_pos  = CW'(m_sy - 3 + int'($urandom % (FOOT + 6)));
        end else if (r == 5) begin
            horiz_pos = '0;
            vert_pos  = CW'(VRES);
        end else if (r == 6) begin
            horiz_pos = CW'($urandom % 3);
            vert_pos  = CW'(m_sy + int'($urandom % FOOT));
        end else begin
            horiz_pos = CW'($urandom);
            vert_pos  = CW'($urandom);
        end
        data_enable = ($urandom % 5) != 0;
        horiz_sync  = 1'($urandom);
        vert_sync   = 1'($urandom);
        if (!req_on && ($urandom % 8) == 0) begin
            req_on = 1'b1;
            pos_x  = CW'(pick_x());
            pos_y  = CW'(pick_y());
        end
        pos_valid = req_on;
    endtask

    initial begin
        bit acc;
        pixel_reset_n = 1'b1;
        pix_ce = 1'b0; horiz_pos = '0; vert_pos = '0;
        data_enable = 1'b0; horiz_sync = 1'b1; vert_sync = 1'b1;
        pos_valid = 1'b0; pos_x = '0; pos_y = '0;
        #2 pixel_reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        pixel_reset_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            drive_inputs();
            @(posedge clk);
            model_edge(acc);
            if (acc) req_on = 1'b0;
            #1;
            check_outputs();
            @(negedge clk);
            if (cyc == 2000) begin
                // Mid-frame reset discards any pending position at once.
                pixel_reset_n = 1'b0;
                #1;
                model_reset();
                check_outputs();
                @(negedge clk);
                pixel_reset_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
